ps2_scancode_fifo: RTL
======================

// Module: ps2_scancode_fifo
// PURPOSE
//  Parametrised PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deframes 11-bit frames,
//  checks start/parity/stop, assembles E0/F0-prefixed scancodes into 32-bit codes and queues
//  them in a show-ahead FIFO so the CPU/game logic never loses keystrokes between polls.
//  Sits between the board PS/2 pins and the memory-mapped keyboard register.
// PARAMETERS
//  DEPTH         8   FIFO entries, power of 2, >=2
//  SYNC_STAGES   2   synchroniser flops on ps2_clk and ps2_data, >=2
//  TIMEOUT_BITS  20  partial-frame abort after 2**(TIMEOUT_BITS-1) clk cycles
//  CHECK_PARITY  1   1 = reject frames with bad odd parity; 0 = ignore parity bit
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  ps2_clk     in   1   raw PS/2 clock pin, asynchronous
//  ps2_data    in   1   raw PS/2 data pin, asynchronous
//  code_data   out  32  FIFO head: {prefix bytes, final byte}, zero-extended on the left
//  code_valid  out  1   FIFO non-empty; code_data is valid
//  code_ready  in   1   pop head when code_valid & code_ready
//  is_break    out  1   code_data[15:8]==8'hF0 (head is a key release)
//  last_code   out  32  most recently pushed code (legacy polled register)
//  fifo_count  out  $clog2(DEPTH+1)  entries in FIFO
//  overflow    out  1   sticky: a code was dropped because FIFO was full
//  frame_err   out  1   sticky: start/stop/parity error seen
//  err_clr     in   1   clears overflow and frame_err
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0; FIFO empty; synchroniser flops to 1; bit count,
//   timeout, prefix register 0. Reset mid-frame discards the partial frame and the prefix.
//  Sync/edge: falling edge = previous synced ps2_clk 1, current 0. Each edge shifts synced
//   ps2_data into an 11-bit register LSB-first (bits <= {data, bits[10:1]}); bit count +1.
//  Frame end: cycle after count reaches 11: count<=0; valid iff bits[0]==0, bits[10]==1 and
//   (!CHECK_PARITY or ^bits[9:1]==1). Invalid: frame_err<=1, prefix cleared, nothing pushed.
//  Timeout: counter runs while count!=0, resets when count==0; when bit TIMEOUT_BITS-1 sets,
//   count<=0, partial frame and prefix discarded, no push, no error flag.
//  Assembly (byte=bits[8:1] of a valid frame): if byte is E0 or F0: prefix <= {prefix[15:0],byte}
//   (oldest prefix byte drops beyond 3), no push. Else: code={prefix,byte}; prefix<=0; push code.
//  Push: code enters FIFO and last_code on the cycle after frame end; code_valid rises that
//   cycle if FIFO was empty (latency 1 clk from frame-end cycle).
//  FIFO: show-ahead; code_data = head combinationally from storage. Pop when code_valid &
//   code_ready. Push when full and no pop: code dropped, overflow<=1, last_code still updates.
//   Push and pop same cycle when full: both occur, count unchanged. Pop when empty: ignored.
//  Pointers wrap modulo DEPTH; fifo_count = pushes - pops, never exceeds DEPTH.
//  Sticky flags: err_clr clears; a set event in the same cycle as err_clr wins (flag = 1).
// TESTING (TIMEOUT_BITS=8, ps2_clk half-period 20 clk)
//  Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) -> code_valid=1, code_data=32'h0000001C,
//   fifo_count=1, last_code=32'h1C; pulse code_ready -> code_valid=0, fifo_count=0.
//  Frames E0,F0,74 -> exactly one entry 32'h00E0F074, is_break=1; frames F0,1C -> 32'h0000F01C.
//  Frame 0x1C with parity bit 1 -> no push, frame_err=1; next good 0x1B -> 32'h1B pushed;
//   err_clr -> frame_err=0.
//  5 bits then idle 200 clk -> abort, fifo_count=0, frame_err=0; next full 0x29 -> 32'h29.
//  DEPTH+1 codes 0x15,0x16,... without pop -> fifo_count=DEPTH, overflow=1, pops return first
//   DEPTH codes in order; last_code = final (dropped) code.
//  reset_n low after 6 bits of a frame -> all outputs 0; subsequent frame 0x1C decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit frame deframer with error checks,
// E0/F0 prefix assembly into 32-bit codes, and a show-ahead FIFO towards the CPU.
module ps2_scancode_fifo #(
    parameter int DEPTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 20,
    parameter int CHECK_PARITY = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    output logic [31:0]                code_data,
    output logic                       code_valid,
    input  logic                       code_ready,
    output logic                       is_break,
    output logic [31:0]                last_code,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // ------------------------------------------------------------------
    // Pin synchronisers and falling-edge detect on the PS/2 clock
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Idle PS/2 lines are high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // ------------------------------------------------------------------
    // Deframer: shift LSB-first, count bits, abort stalled partial frames
    // ------------------------------------------------------------------
    logic [10:0]             bits;
    logic [3:0]              bit_cnt;
    logic [TIMEOUT_BITS-1:0] tmo_cnt;
    logic                    frame_end;
    logic                    timeout;
    logic                    parity_ok;
    logic                    frame_ok;
    logic [7:0]              rx_byte;
    logic                    is_prefix;

    assign frame_end = (bit_cnt == 4'd11);
    assign timeout   = tmo_cnt[TIMEOUT_BITS-1];
    assign parity_ok = (CHECK_PARITY == 0) || (^bits[9:1]);
    assign frame_ok  = ~bits[0] & bits[10] & parity_ok;
    assign rx_byte   = bits[8:1];
    assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);

    // The timeout measures the gap since the last edge, so each edge restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bits    <= '0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else if (frame_end || timeout) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else if (fall) begin
            bits    <= {data_s, bits[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
        end else if (bit_cnt != 4'd0) begin
            tmo_cnt <= tmo_cnt + TIMEOUT_BITS'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Prefix assembly
    // ------------------------------------------------------------------
    logic [23:0] prefix;
    logic        push;
    logic [31:0] push_code;
    logic        frame_bad;

    assign push      = frame_end & frame_ok & ~is_prefix;
    assign push_code = {prefix, rx_byte};
    assign frame_bad = frame_end & ~frame_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prefix <= '0;
        end else if (frame_end) begin
            if (frame_ok && is_prefix) prefix <= {prefix[15:0], rx_byte};
            else                       prefix <= '0;
        end else if (timeout) begin
            prefix <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          ovf_set;

    assign full    = (count == CW'(DEPTH));
    assign pop     = code_valid & code_ready;
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    // NOTE: storage has no reset; occupancy is tracked by count and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Legacy register and sticky error flags (a set beats a clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_code <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push) last_code <= push_code;
            overflow  <= (overflow  & ~err_clr) | ovf_set;
            frame_err <= (frame_err & ~err_clr) | frame_bad;
        end
    end

    assign code_valid = (count != '0);
    assign code_data  = code_valid ? mem[rd_ptr] : '0;
    assign is_break   = (code_data[15:8] == 8'hF0);
    assign fifo_count = count;

endmodule
